// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with status flags and an optional iterative restoring divider.
// Define ALU_SEQ_DIV_EN to build the divider; without it opcodes 0011/0100 complete at once as illegal.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_dz,
   output logic             flag_illegal
);

`ifdef ALU_SEQ_DIV_EN
   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
`else
   typedef enum logic [0:0] {IDLE, HOLD} state_t;
`endif

   state_t               state, state_n;
   logic                 accept;
   logic                 ld_single;
   logic [WIDTH-1:0]     res_c;
   logic                 carry_c, dz_c, ill_c;
   logic [2*WIDTH-1:0]   prod;

   assign accept = in_ready && in_valid;
   assign prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

`ifdef ALU_SEQ_DIV_EN
   localparam int CW = $clog2(WIDTH + 1);

   logic                 div_start;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     quo, rem, dvs, quo_n, rem_n, fin;
   logic [WIDTH:0]       trial;
   logic                 is_mod;

   assign ld_single = accept && !div_start;
`else
   assign ld_single = accept;
`endif

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      dz_c    = 1'b0;
      ill_c   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_start = 1'b0;
`endif
      case (op)
         4'b0000: {carry_c, res_c} = {1'b0, a} + {1'b0, b};
         4'b0001: begin res_c = a - b; carry_c = (a < b); end
         4'b0010: begin res_c = prod[WIDTH-1:0]; carry_c = |prod[2*WIDTH-1:WIDTH]; end
         4'b0011, 4'b0100: begin
`ifdef ALU_SEQ_DIV_EN
            // Division by zero is resolved immediately; only real divides enter the iterator.
            if (b == '0) begin
               dz_c  = 1'b1;
               res_c = (op == 4'b0011) ? '1 : a;
            end else begin
               div_start = 1'b1;
            end
`else
            ill_c = 1'b1;
`endif
         end
         4'b0101: res_c = a & b;
         4'b0110: res_c = a | b;
         4'b0111: res_c[0] = (a != '0) && (b != '0);
         4'b1000: res_c[0] = (a != '0) || (b != '0);
         4'b1001: res_c = a ^ b;
         4'b1010: res_c = ~a;
         4'b1011: res_c[0] = (a == '0);
         4'b1100: begin res_c = a >> 1; carry_c = a[0]; end
         4'b1101: begin res_c = a << 1; carry_c = a[WIDTH-1]; end
         4'b1110: {carry_c, res_c} = {1'b0, a} + (WIDTH+1)'(1);
         4'b1111: begin res_c = a - WIDTH'(1); carry_c = (a == '0); end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
`ifdef ALU_SEQ_DIV_EN
               state_n = div_start ? BUSY : HOLD;
`else
               state_n = HOLD;
`endif
            end
         end
`ifdef ALU_SEQ_DIV_EN
         BUSY: if (cnt == CW'(1)) state_n = HOLD;
`endif
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef ALU_SEQ_DIV_EN
   // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
   always_comb begin
      trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
      if (trial[WIDTH]) begin
         rem_n = {rem[WIDTH-2:0], quo[WIDTH-1]};
         quo_n = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_n = trial[WIDTH-1:0];
         quo_n = {quo[WIDTH-2:0], 1'b1};
      end
   end

   assign fin = is_mod ? rem_n : quo_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   cnt <= '0;
      else if (accept && div_start) cnt <= CW'(WIDTH);
      else if (state == BUSY)       cnt <= cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (accept && div_start) begin
         quo    <= a;
         rem    <= '0;
         dvs    <= b;
         is_mod <= (op == 4'b0100);
      end else if (state == BUSY) begin
         quo <= quo_n;
         rem <= rem_n;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result       <= '0;
         flag_zero    <= 1'b0;
         flag_carry   <= 1'b0;
         flag_dz      <= 1'b0;
         flag_illegal <= 1'b0;
      end else if (ld_single) begin
         result       <= res_c;
         flag_zero    <= (res_c == '0);
         flag_carry   <= carry_c;
         flag_dz      <= dz_c;
         flag_illegal <= ill_c;
`ifdef ALU_SEQ_DIV_EN
      end else if (state == BUSY && cnt == CW'(1)) begin
         result       <= fin;
         flag_zero    <= (fin == '0);
         flag_carry   <= 1'b0;
         flag_dz      <= 1'b0;
         flag_illegal <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq (WIDTH=8) against a plain-arithmetic model.
// Divide expectations follow ALU_SEQ_DIV_EN exactly as the design build does.
`timescale 1ns/1ps
module tb_alu_seq;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   op = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] result;
   logic         flag_zero, flag_carry, flag_dz, flag_illegal;
   int           n_checks = 0;
   int           n_pass = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry),
      .flag_dz(flag_dz), .flag_illegal(flag_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: {result, zero, carry, dz, illegal} plus expected edges from acceptance to out_valid.
   function automatic logic [11:0] model(input int x, input int y, input int o, output int lat);
      int m;
      int r;
      logic c, dz, il;
      logic [W-1:0] rv;
      m = 1 << W; r = 0; c = 1'b0; dz = 1'b0; il = 1'b0; lat = 0;
      case (o)
         0:  begin r = (x + y) % m; c = ((x + y) >= m); end
         1:  begin r = (x - y + m) % m; c = (x < y); end
         2:  begin r = (x * y) % m; c = ((x * y) >= m); end
         3, 4: begin
`ifdef ALU_SEQ_DIV_EN
            if (y == 0) begin dz = 1'b1; r = (o == 3) ? m - 1 : x; end
            else begin r = (o == 3) ? x / y : x % y; lat = W; end
`else
            il = 1'b1;
`endif
         end
         5:  r = x & y;
         6:  r = x | y;
         7:  r = (x != 0 && y != 0) ? 1 : 0;
         8:  r = (x != 0 || y != 0) ? 1 : 0;
         9:  r = x ^ y;
         10: r = m - 1 - x;
         11: r = (x == 0) ? 1 : 0;
         12: begin r = x / 2; c = (x % 2 == 1); end
         13: begin r = (x * 2) % m; c = (x >= m / 2); end
         14: begin r = (x + 1) % m; c = (x + 1 == m); end
         default: begin r = (x - 1 + m) % m; c = (x == 0); end
      endcase
      rv = r[W-1:0];
      return {rv, (r == 0), c, dz, il};
   endfunction

   // Drives one transaction, reports observed outputs, edges until out_valid, and whether in_ready rose meanwhile.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [3:0] to,
                         input int hold, output logic [11:0] obs, output int lat, output logic rs);
      int w;
      @(negedge clk);
      a = ta; b = tbv; op = to; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
      lat = 0; rs = 1'b0;
      while (!out_valid && lat < 100) begin
         rs = rs | in_ready;
         @(posedge clk); #1;
         lat++;
      end
      obs = {result, flag_zero, flag_carry, flag_dz, flag_illegal};
      repeat (hold) @(posedge clk);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] st;
      #3 rst_n = 1'b0;
      #1;
      st = {in_ready, out_valid, result, flag_zero, flag_carry, flag_dz, flag_illegal};
      n_checks++;
      if (st !== {1'b1, 13'b0}) $display("FAIL reset_state: got %h want %h", st, {1'b1, 13'b0});
      else n_pass++;
      in_valid = 1'b1; a = 8'd1; b = 8'd2;
      @(posedge clk); #1;
      st = {in_ready, out_valid, result, flag_zero, flag_carry, flag_dz, flag_illegal};
      n_checks++;
      if (st !== {1'b1, 13'b0}) $display("FAIL reset_held_edge: got %h want %h", st, {1'b1, 13'b0});
      else n_pass++;
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_single_cycle();
      logic [W-1:0] va[4], vb[4];
      logic [3:0]   vo[4];
      logic [11:0]  ve[4];
      logic [11:0]  obs;
      int           lat;
      logic         rs;
      va = '{8'd200, 8'h81, 8'd0, 8'h10};
      vb = '{8'd100, 8'd0, 8'd0, 8'h00};
      vo = '{4'b0000, 4'b1101, 4'b1111, 4'b0111};
      ve = '{{8'd44, 4'b0100}, {8'h02, 4'b0100}, {8'hFF, 4'b0100}, {8'h00, 4'b1000}};
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], vo[i], 0, obs, lat, rs);
         n_checks++;
         if (obs !== ve[i]) $display("FAIL single_%0d: got %h want %h", i, obs, ve[i]);
         else n_pass++;
         n_checks++;
         if (lat !== 0) $display("FAIL single_lat_%0d: got %0d want 0", i, lat);
         else n_pass++;
      end
   endtask

   task automatic test_divide();
      logic [W-1:0] va[4], vb[4];
      logic [3:0]   vo[4];
      logic [11:0]  ve[4];
      int           vl[4];
      logic [11:0]  obs;
      int           lat;
      logic         rs;
      va = '{8'd200, 8'd200, 8'd55, 8'd55};
      vb = '{8'd7, 8'd7, 8'd0, 8'd0};
      vo = '{4'b0011, 4'b0100, 4'b0011, 4'b0100};
`ifdef ALU_SEQ_DIV_EN
      ve = '{{8'd28, 4'b0000}, {8'd4, 4'b0000}, {8'd255, 4'b0010}, {8'd55, 4'b0010}};
      vl = '{8, 8, 0, 0};
`else
      ve = '{{8'd0, 4'b1001}, {8'd0, 4'b1001}, {8'd0, 4'b1001}, {8'd0, 4'b1001}};
      vl = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], vo[i], 1, obs, lat, rs);
         n_checks++;
         if (obs !== ve[i]) $display("FAIL divide_%0d: got %h want %h", i, obs, ve[i]);
         else n_pass++;
         n_checks++;
         if (lat !== vl[i]) $display("FAIL divide_lat_%0d: got %0d want %0d", i, lat, vl[i]);
         else n_pass++;
         n_checks++;
         if (rs !== 1'b0) $display("FAIL divide_ready_busy_%0d: got %b want 0", i, rs);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      logic [13:0] st;
      @(negedge clk);
      a = 8'd9; b = 8'd5; op = 4'b0001; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 4'b0000;
         @(posedge clk); #1;
         st = {out_valid, in_ready, result, flag_zero, flag_carry, flag_dz, flag_illegal};
         n_checks++;
         if (st !== {2'b10, 8'd4, 4'b0000}) $display("FAIL hold_stable_%0d: got %h want %h", i, st, {2'b10, 8'd4, 4'b0000});
         else n_pass++;
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) $display("FAIL hold_release: got %b want 01", {out_valid, in_ready});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) $display("FAIL hold_no_accept: got %b want 01", {out_valid, in_ready});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [11:0] q[$];
      logic [11:0] exp, obs;
      logic [W-1:0] ta, tbv;
      logic [3:0]  to;
      int          lat, nres;
      nres = 0;
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         if (in_ready) begin
            ta = 8'($urandom); tbv = 8'($urandom); to = 4'($urandom);
            if (to == 4'd3 || to == 4'd4) to = 4'd0;
            q.push_back(model(int'(ta), int'(tbv), int'(to), lat));
            a = ta; b = tbv; op = to; in_valid = 1'b1;
         end
         @(posedge clk); #1;
         if (out_valid) begin
            nres++;
            obs = {result, flag_zero, flag_carry, flag_dz, flag_illegal};
            if (q.size() > 0) begin
               exp = q.pop_front();
               n_checks++;
               if (obs !== exp) $display("FAIL b2b_result_%0d: got %h want %h", i, obs, exp);
               else n_pass++;
            end
         end
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
      n_checks++;
      if (nres !== 6) $display("FAIL b2b_throughput: got %0d results want 6", nres);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [W-1:0] ta, tbv;
      logic [3:0]   to;
      logic [11:0]  exp, obs;
      int           elat, lat;
      logic         rs;
      for (int i = 0; i < 40; i++) begin
         ta  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         tbv = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         to  = 4'($urandom);
         exp = model(int'(ta), int'(tbv), int'(to), elat);
         run_op(ta, tbv, to, $urandom_range(0, 2), obs, lat, rs);
         n_checks++;
         if (obs !== exp) $display("FAIL random_%0d op=%h a=%0d b=%0d: got %h want %h", i, to, ta, tbv, obs, exp);
         else n_pass++;
         n_checks++;
         if (lat !== elat) $display("FAIL random_lat_%0d op=%h: got %0d want %0d", i, to, lat, elat);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_divide();
      logic [13:0] st;
      logic [11:0] obs;
      int          lat;
      logic        rs;
      @(negedge clk);
      a = 8'd200; b = 8'd7; op = 4'b0011; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      st = {in_ready, out_valid, result, flag_zero, flag_carry, flag_dz, flag_illegal};
      n_checks++;
      if (st !== {1'b1, 13'b0}) $display("FAIL reset_mid_divide: got %h want %h", st, {1'b1, 13'b0});
      else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      run_op(8'd3, 8'd4, 4'b0000, 0, obs, lat, rs);
      n_checks++;
      if (obs !== {8'd7, 4'b0000}) $display("FAIL add_after_reset: got %h want %h", obs, {8'd7, 4'b0000});
      else n_pass++;
      n_checks++;
      if (lat !== 0) $display("FAIL add_after_reset_lat: got %0d want 0", lat);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_divide();
      test_hold();
      test_back_to_back();
      test_random();
      test_reset_mid_divide();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
